// File: rtl/interleaver_pkg.sv
// interleaver_pkg: constants shared by the convolutional interleaver and deinterleaver
//   I, M, W  : branch count, delay-unit depth, data width
//   D        : end-to-end delay in accepted bytes
//   BR_W     : commutator index width, FILL_W: fill counter width
//   depth(j) : deinterleaver depth of branch j
package interleaver_pkg;
  localparam int I = 12;
  localparam int M = 17;
  localparam int W = 8;
  localparam int D = I * M * (I - 1);
  localparam int BR_W = $clog2(I);
  localparam int FILL_W = $clog2(D + 1);
  function automatic int depth(input int j);
    return (I - 1 - j) * M;
  endfunction
endpackage

// File: rtl/deint_branch.sv
// deint_branch: enable-gated delay line of DEPTH words, DEPTH=0 is a pass-through
//   clk, reset : clock, synchronous active-high reset (clears storage)
//   en         : shift d in; q is the oldest word before the shift
//   d, q       : data in / data out
module deint_branch #(
  parameter int DEPTH = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused = ^{clk, reset, en};
    assign q = d;
  end else begin : g_dly
    logic [W-1:0] sr_q [DEPTH];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
      end else if (en) begin
        sr_q[0] <= d;
        for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
      end
    end
    assign q = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/conv_deinterleaver.sv
// conv_deinterleaver: Forney convolutional byte deinterleaver, I branches of depth (I-1-j)*M
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/data/sync  : input byte, in_sync marks a branch-0 byte
//   out_valid/data      : registered output byte, one cycle after accept
//   out_branch          : branch the output byte came from
//   out_locked          : pipeline primed with real data
//   DEINT_SYNC_ALIGN_EN : when defined, in_sync re-aligns the commutator to branch 0
module conv_deinterleaver
  import interleaver_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  input  logic            in_sync,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [BR_W-1:0] out_branch,
  output logic            out_locked
);
  logic [BR_W-1:0]   br_q, br_d, sel;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              realign;
  logic [I-1:0]      en;
  logic [W-1:0]      bq [I];
`ifdef DEINT_SYNC_ALIGN_EN
  assign realign = in_valid && in_sync && br_q != '0;
`else
  logic unused;
  assign unused = in_sync;
  assign realign = 1'b0;
`endif
  // a re-aligning byte goes to branch 0 and restarts priming; storage is kept
  always_comb begin
    sel = realign ? '0 : br_q;
    br_d = !in_valid ? br_q : sel == BR_W'(I - 1) ? '0 : sel + 1'b1;
    fill_d = realign ? '0 : (in_valid && fill_q != FILL_W'(D)) ? fill_q + 1'b1 : fill_q;
  end
  for (genvar j = 0; j < I; j++) begin : g_br
    assign en[j] = in_valid && sel == BR_W'(j);
    deint_branch #(.DEPTH(depth(j)), .W(W)) u_br (
      .clk  (clk),
      .reset(reset),
      .en   (en[j]),
      .d    (in_data),
      .q    (bq[j])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      br_q <= '0;
      fill_q <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_branch <= '0;
      out_locked <= 1'b0;
    end else begin
      br_q <= br_d;
      fill_q <= fill_d;
      out_valid <= in_valid;
      out_locked <= fill_d == FILL_W'(D);
      if (in_valid) begin
        out_data <= bq[sel];
        out_branch <= sel;
      end
    end
  end
endmodule

// File: tb/tb_conv_deinterleaver.sv
// tb_conv_deinterleaver: scoreboard bench for conv_deinterleaver (ramp, loopback, gaps, reset, sync)
module tb_conv_deinterleaver;
  import interleaver_pkg::*;
  typedef struct {
    logic            cd;
    logic [W-1:0]    d;
    logic [BR_W-1:0] b;
    logic            lk;
  } exp_t;
`ifdef DEINT_SYNC_ALIGN_EN
  localparam bit SA = 1'b1;
`else
  localparam bit SA = 1'b0;
`endif
  logic            clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_sync = 1'b0;
  logic [W-1:0]    in_data = '0;
  logic            out_valid, out_locked;
  logic [W-1:0]    out_data;
  logic [BR_W-1:0] out_branch;
  exp_t            sb [$];
  exp_t            me;
  int              n_tests = 0, n_fail = 0, eb = 0, fc = 0;
  bit              mon = 1'b0;
  logic            pv = 1'b0;
  logic [W-1:0]    xs [5000];
  logic [W-1:0]    ilm [I][(I-1)*M];
  int              ip [I];
  logic [W-1:0]    last_d;
  logic [BR_W-1:0] last_b;
  always #5 clk = ~clk;
  conv_deinterleaver dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sync   (in_sync),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_branch(out_branch),
    .out_locked(out_locked)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] rexp(input int k);
    int dl;
    dl = (I - 1 - k % I) * M * I;
    return k >= dl ? W'(k - dl) : '0;
  endfunction
  task automatic send(input logic [W-1:0] d, input logic s, input logic cd, input logic [W-1:0] ed);
    exp_t e;
    int b;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = d;
    in_sync = s;
    b = eb;
    if (SA && s && eb != 0) begin
      b = 0;
      fc = 0;
    end else if (fc < D) fc++;
    eb = (b == I - 1) ? 0 : b + 1;
    e.cd = cd;
    e.d = ed;
    e.b = BR_W'(b);
    e.lk = (fc == D);
    sb.push_back(e);
    last_d = ed;
    last_b = e.b;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sync = 1'b0;
    end
  endtask
  task automatic do_reset;
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    in_sync = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    eb = 0;
    fc = 0;
    mon = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_branch", out_branch, 0);
    chk("rst_locked", out_locked, 0);
    chk("rst_br", dut.br_q, 0);
    chk("rst_fill", dut.fill_q, 0);
    for (int j = 0; j < I; j++) begin
      ip[j] = 0;
      for (int k = 0; k < (I-1)*M; k++) ilm[j][k] = '0;
    end
  endtask
  task automatic ramp(input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) send(W'(k), 1'b0, 1'b1, rexp(k));
  endtask
  // golden transmit interleaver: branch j delays j*M visits
  task automatic loop(input bit gaps);
    for (int n = 0; n < 5000; n++) begin
      logic [W-1:0] y;
      int j;
      j = n % I;
      if (gaps) while ($urandom_range(99) < 30) idle(1);
      if (j == 0) y = xs[n];
      else begin
        y = ilm[j][ip[j]];
        ilm[j][ip[j]] = xs[n];
        ip[j] = (ip[j] + 1) % (j * M);
      end
      send(y, 1'b0, 1'b1, n >= D ? xs[n-D] : '0);
    end
  endtask
  always @(negedge clk) begin
    if (mon) begin
      chk("valid", out_valid, pv);
      pv = in_valid && !reset;
      if (out_valid) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          me = sb.pop_front();
          if (me.cd) chk("data", out_data, me.d);
          chk("branch", out_branch, me.b);
          chk("locked", out_locked, me.lk);
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1);
  end
  initial begin
    for (int n = 0; n < 5000; n++) xs[n] = W'($urandom);
    do_reset;
    ramp(0, 300);
    idle(3);
    do_reset;
    loop(1'b0);
    idle(3);
    do_reset;
    loop(1'b1);
    idle(3);
    do_reset;
    ramp(0, 500);
    do_reset;
    ramp(0, 300);
    idle(2);
    do_reset;
    ramp(0, 150);
    idle(100);
    chk("gap_data", out_data, last_d);
    chk("gap_branch", out_branch, last_b);
    chk("gap_br", dut.br_q, eb);
    ramp(150, 150);
    idle(2);
    do_reset;
    ramp(0, 2273);
    send(W'(2273), 1'b1, !SA, rexp(2273));
    for (int k = 2274; k < 2274 + D; k++) send(W'(k), 1'b0, !SA, rexp(k));
    idle(3);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
